// File: rtl/layer_sequencer_if.sv
// Link from the sequencer to the accelerator top: per-layer launch/config/done
// handshake plus the read port into result memory A1.
`timescale 1ns/1ps
interface layer_sequencer_if #(
  parameter int DATA_W = 16
);
  logic              go;
  logic [2:0]        layer_index;
  logic [31:0]       data_address;
  logic [31:0]       data_size;
  logic [31:0]       weight_address;
  logic [31:0]       weight_size;
  logic [31:0]       result_address;
  logic [31:0]       result_size;
  logic              done;
  logic              rd_en;
  logic [31:0]       rd_addr;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output go, layer_index, data_address, data_size, weight_address,
           weight_size, result_address, result_size, rd_en, rd_addr,
    input  done, rd_data
  );

  modport slave (
    input  go, layer_index, data_address, data_size, weight_address,
           weight_size, result_address, result_size, rd_en, rd_addr,
    output done, rd_data
  );
endinterface

// File: rtl/layer_sequencer.sv
// Runs the five MNIST layers back to back (one go/done per layer), then scans the
// dense logits in memory A1 and reports the signed argmax; a per-layer timeout aborts.
`timescale 1ns/1ps
module layer_sequencer #(
  parameter int DATA_W      = 16,
  parameter int NUM_CLASSES = 10,
  parameter int GAP_CYCLES  = 2,
  parameter int TIMEOUT     = 1 << 22
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  output logic                 busy,
  output logic                 net_done,
  output logic [3:0]           class_out,
  output logic                 class_valid,
  output logic                 error,
  layer_sequencer_if.master    bus
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_SETUP = 4'd1;
  localparam logic [3:0] S_GO    = 4'd2;
  localparam logic [3:0] S_ARM   = 4'd3;
  localparam logic [3:0] S_WAIT  = 4'd4;
  localparam logic [3:0] S_GAP   = 4'd5;
  localparam logic [3:0] S_RD    = 4'd6;
  localparam logic [3:0] S_CMP   = 4'd7;
  localparam logic [3:0] S_DONE  = 4'd8;

  localparam logic [2:0] LAST_LAYER = 3'd4;

  typedef struct packed {
    logic [31:0] da;
    logic [31:0] ds;
    logic [31:0] wa;
    logic [31:0] ws;
    logic [31:0] ra;
    logic [31:0] rs;
  } cfg_t;

  function automatic cfg_t layer_cfg(input logic [2:0] idx);
    cfg_t c;
    c = '0;
    case (idx)
      3'd0: begin c.ds = 32'd1764; c.ws = 32'd40;  c.rs = 32'd6400; end
      3'd1: begin c.ds = 32'd6400;                 c.rs = 32'd1600; end
      3'd2: begin c.ds = 32'd1600; c.wa = 32'd40;  c.ws = 32'd148;  c.rs = 32'd1296; end
      3'd3: begin c.ds = 32'd1296;                 c.rs = 32'd324;  end
      3'd4: begin c.ds = 32'd324;  c.wa = 32'd188; c.ws = 32'd3250; c.rs = 32'd10;   end
      default: ;
    endcase
    return c;
  endfunction

  logic [3:0]               state_q, state_d;
  logic [2:0]               layer_q, layer_d;
  cfg_t                     cfg_q, cfg_d;
  logic [31:0]              cnt_q, cnt_d;
  logic                     busy_q, busy_d;
  logic                     net_done_q, net_done_d;
  logic [3:0]               class_out_q, class_out_d;
  logic                     class_valid_q, class_valid_d;
  logic                     error_q, error_d;
  logic [3:0]               best_idx_q, best_idx_d;
  logic signed [DATA_W-1:0] best_val_q, best_val_d;
  logic                     smp_vld_q;
  logic [3:0]               smp_idx_q;
  logic signed [DATA_W-1:0] sample;
  logic                     take;

  // Read data lags rd_en by one cycle, so the index rides along in smp_idx_q.
  assign sample     = $signed(bus.rd_data);
  assign take       = smp_vld_q && ((smp_idx_q == 4'd0) || (sample > best_val_q));
  assign best_idx_d = take ? smp_idx_q : best_idx_q;
  assign best_val_d = take ? sample : best_val_q;

  always_comb begin
    state_d       = state_q;
    layer_d       = layer_q;
    cfg_d         = cfg_q;
    cnt_d         = cnt_q;
    busy_d        = busy_q;
    net_done_d    = 1'b0;
    class_out_d   = class_out_q;
    class_valid_d = class_valid_q;
    error_d       = error_q;
    case (state_q)
      S_IDLE: begin
        // A start coinciding with a net_done pulse is dropped.
        if (start && !net_done_q) begin
          busy_d        = 1'b1;
          error_d       = 1'b0;
          class_valid_d = 1'b0;
          layer_d       = 3'd0;
          state_d       = S_SETUP;
        end
      end
      S_SETUP: state_d = S_GO;
      S_GO:    state_d = S_ARM;
      S_ARM: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.done) begin
          cnt_d   = '0;
          state_d = S_GAP;
        end else if (cnt_q == 32'(TIMEOUT - 1)) begin
          error_d    = 1'b1;
          net_done_d = 1'b1;
          busy_d     = 1'b0;
          state_d    = S_IDLE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_GAP: begin
        if (cnt_q == 32'(GAP_CYCLES - 1)) begin
          cnt_d = '0;
          if (layer_q == LAST_LAYER) begin
            state_d = S_RD;
          end else begin
            layer_d = layer_q + 3'd1;
            state_d = S_SETUP;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_RD: begin
        if (cnt_q == 32'(NUM_CLASSES - 1)) begin
          cnt_d   = '0;
          state_d = S_CMP;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_CMP: begin
        class_out_d   = best_idx_d;
        class_valid_d = 1'b1;
        net_done_d    = 1'b1;
        busy_d        = 1'b0;
        state_d       = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Config is loaded on entry to SETUP so it is stable a full cycle before go.
    if (state_d == S_SETUP) begin
      cfg_d = layer_cfg(layer_d);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= S_IDLE;
      layer_q       <= '0;
      cfg_q         <= '0;
      cnt_q         <= '0;
      busy_q        <= 1'b0;
      net_done_q    <= 1'b0;
      class_out_q   <= '0;
      class_valid_q <= 1'b0;
      error_q       <= 1'b0;
      best_idx_q    <= '0;
      best_val_q    <= '0;
      smp_vld_q     <= 1'b0;
      smp_idx_q     <= '0;
    end else begin
      state_q       <= state_d;
      layer_q       <= layer_d;
      cfg_q         <= cfg_d;
      cnt_q         <= cnt_d;
      busy_q        <= busy_d;
      net_done_q    <= net_done_d;
      class_out_q   <= class_out_d;
      class_valid_q <= class_valid_d;
      error_q       <= error_d;
      best_idx_q    <= best_idx_d;
      best_val_q    <= best_val_d;
      smp_vld_q     <= (state_q == S_RD);
      smp_idx_q     <= cnt_q[3:0];
    end
  end

  assign busy               = busy_q;
  assign net_done           = net_done_q;
  assign class_out          = class_out_q;
  assign class_valid        = class_valid_q;
  assign error              = error_q;
  assign bus.go             = (state_q == S_GO);
  assign bus.rd_en          = (state_q == S_RD);
  assign bus.rd_addr        = (state_q == S_RD) ? (cfg_q.ra + cnt_q) : 32'd0;
  assign bus.layer_index    = layer_q;
  assign bus.data_address   = cfg_q.da;
  assign bus.data_size      = cfg_q.ds;
  assign bus.weight_address = cfg_q.wa;
  assign bus.weight_size    = cfg_q.ws;
  assign bus.result_address = cfg_q.ra;
  assign bus.result_size    = cfg_q.rs;

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: a modelled accelerator top and memory A1 react to go/rd_en,
// and each scenario checks classification, handshake counts, timeout and reset behaviour.
`timescale 1ns/1ps
module tb_layer_sequencer;
  localparam int DW = 16;
  localparam int NC = 10;
  localparam int TO = 64;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       start = 1'b0;
  logic       busy, net_done, class_valid, error;
  logic [3:0] class_out;

  layer_sequencer_if #(.DATA_W(DW)) bus ();

  layer_sequencer #(.DATA_W(DW), .NUM_CLASSES(NC), .GAP_CYCLES(2), .TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn), .start(start), .busy(busy), .net_done(net_done),
    .class_out(class_out), .class_valid(class_valid), .error(error), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_cfg [5][6] = '{
    '{32'd0, 32'd1764, 32'd0,   32'd40,   32'd0, 32'd6400},
    '{32'd0, 32'd6400, 32'd0,   32'd0,    32'd0, 32'd1600},
    '{32'd0, 32'd1600, 32'd40,  32'd148,  32'd0, 32'd1296},
    '{32'd0, 32'd1296, 32'd0,   32'd0,    32'd0, 32'd324},
    '{32'd0, 32'd324,  32'd188, 32'd3250, 32'd0, 32'd10}
  };

  logic signed [DW-1:0] mem [NC];
  int   delay_of [5];
  int   hang_layer = -1;
  bit   sticky = 0;
  int   go_count, nd_count, drift, rd_bad;
  int   go_layers [$];

  function automatic logic [191:0] cfg_now();
    return {bus.data_address, bus.data_size, bus.weight_address,
            bus.weight_size, bus.result_address, bus.result_size};
  endfunction

  function automatic int ref_argmax();
    int best = 0;
    for (int i = 1; i < NC; i++) if (mem[i] > mem[best]) best = i;
    return best;
  endfunction

  // Accelerator top + memory A1 model: done a programmed delay after go, read data one cycle after rd_en.
  initial begin : top_model
    int                   cnt_left;
    bit                   watching;
    logic [191:0]         snap, prev;
    logic signed [DW-1:0] pend;
    int                   lay;
    bus.done = 1'b0; bus.rd_data = '0;
    cnt_left = -1; watching = 0; snap = '0; prev = '0; pend = '0;
    forever begin
      @(posedge clk); #1;
      if (!rstn) begin
        bus.done = 1'b0; bus.rd_data = '0; pend = '0; cnt_left = -1; watching = 0;
      end else begin
        bus.rd_data = pend;
        pend = '0;
        if (bus.rd_en) begin
          if (bus.rd_addr < NC) pend = mem[bus.rd_addr];
          else rd_bad++;
        end
        if (net_done) nd_count++;
        if (bus.go) begin
          go_count++;
          lay = int'(bus.layer_index);
          go_layers.push_back(lay);
          checks++;
          if (lay > 4 || cfg_now() !== {ref_cfg[lay][0], ref_cfg[lay][1], ref_cfg[lay][2],
                                        ref_cfg[lay][3], ref_cfg[lay][4], ref_cfg[lay][5]}) begin
            errors++;
            $display("FAIL cfg_at_go layer %0d got %h", lay, cfg_now());
          end
          if (prev !== cfg_now()) drift++;
          snap = cfg_now();
          watching = 1;
          cnt_left = (lay == hang_layer) ? -1 : delay_of[lay % 5];
          if (!sticky) bus.done = 1'b0;
        end else begin
          if (watching && cfg_now() !== snap) drift++;
          if (cnt_left > 0) cnt_left--;
          if (cnt_left == 0) begin
            bus.done = 1'b1; cnt_left = -1; watching = 0;
          end
        end
        prev = cfg_now();
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    go_count = 0; nd_count = 0; drift = 0; rd_bad = 0;
    go_layers.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_net_done(input int bound, output bit ok);
    ok = 0;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk); #1;
      if (net_done) begin ok = 1; break; end
    end
  endtask

  function automatic bit seq_ok(input int n);
    if (go_layers.size() != n) return 0;
    for (int i = 0; i < n; i++) if (go_layers[i] != i) return 0;
    return 1;
  endfunction

  task automatic test_reset();
    rstn = 1'b0;
    cycles(3);
    checks++;
    if ({busy, net_done, class_valid, error, bus.go, bus.rd_en} !== 6'b0) begin
      errors++; $display("FAIL reset_flags got %b want 000000", {busy, net_done, class_valid, error, bus.go, bus.rd_en});
    end
    checks++;
    if ({class_out, bus.layer_index} !== 7'b0) begin
      errors++; $display("FAIL reset_class_layer got %h want 0", {class_out, bus.layer_index});
    end
    checks++;
    if ({cfg_now(), bus.rd_addr} !== 224'b0) begin
      errors++; $display("FAIL reset_cfg got %h want 0", {cfg_now(), bus.rd_addr});
    end
    rstn = 1'b1;
    cycles(2);
  endtask

  task automatic test_basic();
    bit ok;
    logic signed [DW-1:0] lg [NC] = '{16'sd3, -16'sd5, 16'sd7, 16'sd7, 16'sd0, 16'sd1, 16'sd2, -16'sd8, 16'sd6, 16'sd4};
    for (int i = 0; i < NC; i++) mem[i] = lg[i];
    for (int i = 0; i < 5; i++) delay_of[i] = 60;
    clear_mon();
    pulse_start();
    checks++;
    if (busy !== 1'b1 || error !== 1'b0 || class_valid !== 1'b0) begin
      errors++; $display("FAIL basic_start_flags got busy=%b err=%b cv=%b want 1 0 0", busy, error, class_valid);
    end
    wait_net_done(2000, ok);
    checks++;
    if (!ok || class_out !== 4'd2) begin
      errors++; $display("FAIL basic_class got %0d (done=%0b) want 2", class_out, ok);
    end
    checks++;
    if (class_valid !== 1'b1 || busy !== 1'b0 || error !== 1'b0) begin
      errors++; $display("FAIL basic_flags got cv=%b busy=%b err=%b want 1 0 0", class_valid, busy, error);
    end
    cycles(5);
    checks++;
    if (!seq_ok(5) || go_count != 5) begin
      errors++; $display("FAIL basic_gos got %0d pulses want 5 in order 0..4", go_count);
    end
    checks++;
    if (drift != 0 || rd_bad != 0) begin
      errors++; $display("FAIL basic_cfg_stable got drift=%0d bad_reads=%0d want 0 0", drift, rd_bad);
    end
    checks++;
    if (class_valid !== 1'b1 || class_out !== 4'd2 || net_done !== 1'b0 || nd_count != 1) begin
      errors++; $display("FAIL basic_hold got cv=%b class=%0d nd_pulses=%0d want 1 2 1", class_valid, class_out, nd_count);
    end
  endtask

  task automatic test_start_ignored();
    bit ok;
    for (int i = 0; i < NC; i++) mem[i] = DW'($urandom);
    for (int i = 0; i < 5; i++) delay_of[i] = int'($urandom_range(1, 40));
    clear_mon();
    pulse_start();
    cycles(20);
    pulse_start();
    wait_net_done(2000, ok);
    // Start asserted in the net_done cycle must be dropped.
    pulse_start();
    cycles(6);
    checks++;
    if (!ok || busy !== 1'b0 || go_count != 5 || nd_count != 1) begin
      errors++; $display("FAIL start_ignored got busy=%b gos=%0d nd=%0d want 0 5 1", busy, go_count, nd_count);
    end
    checks++;
    if (class_out !== 4'(ref_argmax())) begin
      errors++; $display("FAIL start_ignored_class got %0d want %0d", class_out, ref_argmax());
    end
  endtask

  task automatic test_stale_done();
    bit ok;
    for (int i = 0; i < NC; i++) mem[i] = DW'($urandom);
    for (int i = 0; i < 5; i++) delay_of[i] = 3;
    sticky = 1;
    clear_mon();
    pulse_start();
    wait_net_done(2000, ok);
    cycles(3);
    checks++;
    if (!ok || !seq_ok(5) || go_count != 5) begin
      errors++; $display("FAIL stale_done_gos got %0d pulses want 5 in order 0..4", go_count);
    end
    checks++;
    if (class_out !== 4'(ref_argmax()) || class_valid !== 1'b1) begin
      errors++; $display("FAIL stale_done_class got %0d want %0d", class_out, ref_argmax());
    end
    sticky = 0;
    bus.done = 1'b0;
  endtask

  task automatic test_extremes();
    bit ok;
    for (int i = 0; i < 5; i++) delay_of[i] = 5;
    for (int i = 0; i < NC; i++) mem[i] = -16'sd32768;
    mem[9] = -16'sd1;
    pulse_start();
    wait_net_done(2000, ok);
    checks++;
    if (!ok || class_out !== 4'd9) begin
      errors++; $display("FAIL extreme_last got %0d want 9", class_out);
    end
    cycles(2);
    begin
      logic signed [DW-1:0] v = DW'($urandom);
      for (int i = 0; i < NC; i++) mem[i] = v;
    end
    pulse_start();
    wait_net_done(2000, ok);
    checks++;
    if (!ok || class_out !== 4'd0) begin
      errors++; $display("FAIL extreme_tie got %0d want 0", class_out);
    end
    cycles(2);
  endtask

  task automatic test_random();
    bit ok;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NC; i++) mem[i] = DW'($urandom);
      if (r == 1) mem[int'($urandom_range(0, 4))] = 16'sd32767;
      for (int i = 0; i < 5; i++) delay_of[i] = int'($urandom_range(1, 60));
      clear_mon();
      pulse_start();
      wait_net_done(2500, ok);
      checks++;
      if (!ok || class_out !== 4'(ref_argmax()) || go_count != 5) begin
        errors++; $display("FAIL random_%0d got class=%0d gos=%0d want %0d 5", r, class_out, go_count, ref_argmax());
      end
      cycles(int'($urandom_range(1, 4)));
    end
  endtask

  task automatic test_timeout();
    bit ok;
    for (int i = 0; i < 5; i++) delay_of[i] = 10;
    hang_layer = 2;
    clear_mon();
    pulse_start();
    wait_net_done(2000, ok);
    checks++;
    if (!ok || error !== 1'b1 || class_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL timeout_flags got nd=%0b err=%b cv=%b busy=%b want 1 1 0 0", ok, error, class_valid, busy);
    end
    cycles(4);
    checks++;
    if (go_count != 3 || error !== 1'b1 || nd_count != 1 || net_done !== 1'b0) begin
      errors++; $display("FAIL timeout_sticky got gos=%0d err=%b nd=%0d want 3 1 1", go_count, error, nd_count);
    end
    hang_layer = -1;
    pulse_start();
    checks++;
    if (error !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL timeout_clear got err=%b busy=%b want 0 1", error, busy);
    end
    wait_net_done(2000, ok);
    cycles(2);
  endtask

  task automatic test_reset_mid();
    bit ok;
    int nd_before;
    for (int i = 0; i < NC; i++) mem[i] = DW'($urandom);
    for (int i = 0; i < 5; i++) delay_of[i] = 30;
    clear_mon();
    pulse_start();
    ok = 0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      cycles(1);
      if (go_layers.size() == 4) ok = 1;
    end
    cycles(6);
    nd_before = nd_count;
    #3 rstn = 1'b0;
    #1;
    checks++;
    if (!ok || {busy, net_done, class_valid, error, bus.go, bus.rd_en, class_out, bus.layer_index} !== 13'b0) begin
      errors++; $display("FAIL midreset_outputs got %b want 0", {busy, net_done, class_valid, error, bus.go, bus.rd_en, class_out, bus.layer_index});
    end
    checks++;
    if ({cfg_now(), bus.rd_addr} !== 224'b0) begin
      errors++; $display("FAIL midreset_cfg got %h want 0", {cfg_now(), bus.rd_addr});
    end
    cycles(3);
    rstn = 1'b1;
    cycles(8);
    checks++;
    if (nd_count != nd_before || busy !== 1'b0) begin
      errors++; $display("FAIL midreset_no_done got nd=%0d busy=%b want %0d 0", nd_count, busy, nd_before);
    end
    for (int i = 0; i < 5; i++) delay_of[i] = int'($urandom_range(1, 50));
    clear_mon();
    pulse_start();
    wait_net_done(2500, ok);
    cycles(2);
    checks++;
    if (!ok || !seq_ok(5) || class_out !== 4'(ref_argmax()) || class_valid !== 1'b1) begin
      errors++; $display("FAIL midreset_rerun got class=%0d gos=%0d want %0d 5", class_out, go_count, ref_argmax());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_start_ignored();
    test_stale_done();
    test_extremes();
    test_random();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
